spi_cmd_exec: RTL and testbench

- Command executor sitting directly downstream of the SPI message interface.
- Consumes the read/write register array that the SPI master writes (rwRegs1D) and executes the tagged command found in RW register 0.
- Publishes status, result and statistics back through the read-only register array (roRegs1D), so the master can poll completion over SPI.
- Single clock domain (sysClk); the external event input is asynchronous and synchronised internally.

---
 rtl/spi_cmd_exec_if.sv | 25 ++
 rtl/spi_cmd_exec.sv | 157 +++++++++++++++
 tb/tb_spi_cmd_exec.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_exec_if.sv
// Register-array link between the SPI message block and the executor.
// master = SPI side, slave = command executor.
interface spi_cmd_exec_if #(
  parameter int nrRWregs = 4,
  parameter int nrROregs = 12
);
  logic [nrRWregs*32-1:0] rwRegs1D;
  logic [nrROregs*32-1:0] roRegs1D;
  logic                   evtIn;
  logic                   busy;

  modport master (
    output rwRegs1D,
    output evtIn,
    input  roRegs1D,
    input  busy
  );

  modport slave (
    input  rwRegs1D,
    input  evtIn,
    output roRegs1D,
    output busy
  );
endinterface

// File: rtl/spi_cmd_exec.sv
// Executes tagged commands from RW reg0, reports status/result
// and a completion count through the RO register array.
module spi_cmd_exec #(
  parameter int nrRWregs = 4,
  parameter int nrROregs = 12
) (
  input logic           sysClk,
  input logic           usrResetN,
  spi_cmd_exec_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ECHO  = 4'h1;
  localparam logic [3:0] OP_DELAY = 4'h2;
  localparam logic [3:0] OP_COUNT = 4'h3;
  localparam logic [3:0] OP_ACCUM = 4'h4;
  localparam logic [3:0] OP_CLEAR = 4'h5;

  state_t      state;
  logic [31:0] cmd;
  logic [31:0] opnd;
  logic [31:0] cmd_prev;
  logic [3:0]  last_tag;
  logic [3:0]  op;
  logic [23:0] n_val;
  logic [23:0] cnt;
  logic [31:0] opa;
  logic [31:0] acc;
  logic [31:0] evt_cnt;
  logic [31:0] result;
  logic [31:0] cmd_count;
  logic [31:0] res_mux;
  logic [3:0]  st_tag;
  logic [3:0]  st_op;
  logic        st_err;
  logic        st_done;
  logic        busy_r;
  logic [2:0]  sync;
  logic        rise;
  logic        accept;
  logic        multi;
  logic [23:0] n_min1;

  assign cmd  = bus.rwRegs1D[31:0];
  assign opnd = bus.rwRegs1D[63:32];

  generate
    if (nrRWregs > 2) begin : g_unused
      logic unused_rw;
      assign unused_rw = ^bus.rwRegs1D[nrRWregs*32-1:64];
    end
  endgenerate

  // sync[1] is the second synchroniser stage, sync[2] its delayed copy
  assign rise = sync[1] & ~sync[2];

  // a stable word with a fresh tag starts a command
  assign accept = (cmd == cmd_prev) && (cmd[31:28] != last_tag);

  assign multi  = (cmd[27:24] == OP_DELAY) ||
                  (cmd[27:24] == OP_COUNT);
  assign n_min1 = (cmd[23:0] == 24'd0) ? 24'd1 : cmd[23:0];

  // result published in DONE; acc already holds the updated value
  always_comb begin
    res_mux = 32'hBADC0DE0;
    unique case (op)
      OP_NOP:   res_mux = 32'd0;
      OP_ECHO:  res_mux = opa;
      OP_DELAY: res_mux = {8'd0, n_val};
      OP_COUNT: res_mux = evt_cnt;
      OP_ACCUM: res_mux = acc;
      OP_CLEAR: res_mux = 32'd0;
      default:  res_mux = 32'hBADC0DE0;
    endcase
  end

  // command FSM, event synchroniser and registered RO fields
  always_ff @(posedge sysClk) begin
    if (!usrResetN) begin
      state     <= IDLE;
      cmd_prev  <= '0;
      last_tag  <= '0;
      op        <= '0;
      n_val     <= '0;
      cnt       <= '0;
      opa       <= '0;
      acc       <= '0;
      evt_cnt   <= '0;
      result    <= '0;
      cmd_count <= '0;
      st_tag    <= '0;
      st_op     <= '0;
      st_err    <= 1'b0;
      st_done   <= 1'b0;
      busy_r    <= 1'b0;
      sync      <= '0;
    end else begin
      cmd_prev <= cmd;
      sync     <= {sync[1:0], bus.evtIn};
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= EXEC;
            last_tag <= cmd[31:28];
            op       <= cmd[27:24];
            n_val    <= cmd[23:0];
            cnt      <= multi ? n_min1 : 24'd1;
            opa      <= opnd;
            evt_cnt  <= '0;
            busy_r   <= 1'b1;
          end
        end
        EXEC: begin
          if (op == OP_COUNT && rise)
            evt_cnt <= evt_cnt + 32'd1;
          if (cnt == 24'd1) begin
            state <= DONE;
            if (op == OP_ACCUM) acc <= acc + opa;
            if (op == OP_CLEAR) acc <= '0;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy_r    <= 1'b0;
          st_tag    <= last_tag;
          st_op     <= op;
          st_err    <= (op > OP_CLEAR);
          st_done   <= 1'b1;
          result    <= res_mux;
          cmd_count <= cmd_count + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RO map: status, result, count; the rest reads as zero
  always_comb begin
    bus.roRegs1D = '0;
    bus.roRegs1D[31:0] = {st_tag, st_op, 21'd0,
                          st_err, st_done, busy_r};
    bus.roRegs1D[63:32] = result;
    bus.roRegs1D[95:64] = cmd_count;
  end

  assign bus.busy = busy_r;

endmodule

// File: tb/tb_spi_cmd_exec.sv
// Scoreboard bench for spi_cmd_exec: expected completions are
// queued at issue time and checked when busy falls.
module tb_spi_cmd_exec;

  logic sysClk = 1'b0;
  logic usrResetN = 1'b0;

  spi_cmd_exec_if #(.nrRWregs(4), .nrROregs(12)) bus();

  spi_cmd_exec #(
    .nrRWregs(4),
    .nrROregs(12)
  ) dut (
    .sysClk(sysClk),
    .usrResetN(usrResetN),
    .bus(bus)
  );

  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [31:0] st;
    logic [31:0] res;
    logic [31:0] cnt;
    int          blen;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          busy_total = 0;
  logic [31:0] acc_m = 0;
  logic [31:0] cnt_m = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ro(input int i);
    return bus.roRegs1D[32*i +: 32];
  endfunction

  // monitor: measure busy length, compare on completion
  initial begin
    int   blen;
    logic prev;
    exp_t e;
    blen = 0;
    prev = 1'b0;
    forever begin
      @(negedge sysClk);
      if (!usrResetN) begin
        blen = 0;
        prev = 1'b0;
      end else begin
        if (bus.busy) begin
          blen++;
          busy_total++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_cmd", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("busy_len", blen, e.blen);
            chk("status", ro(0), e.st);
            chk("result", ro(1), e.res);
            chk("count", ro(2), e.cnt);
          end
          blen = 0;
        end
        prev = bus.busy;
      end
    end
  end

  task automatic set_rw(input logic [31:0] cmd,
                        input logic [31:0] a);
    @(posedge sysClk);
    #1;
    bus.rwRegs1D = {64'd0, a, cmd};
  endtask

  // push the expected completion, then write the command
  task automatic issue(input logic [31:0] cmd,
                       input logic [31:0] a,
                       input logic [31:0] evt);
    exp_t        e;
    logic [3:0]  op;
    logic [23:0] n;
    int          nn;
    op = cmd[27:24];
    n  = cmd[23:0];
    nn = (n == 0) ? 1 : int'(n);
    case (op)
      4'h0: e.res = 32'd0;
      4'h1: e.res = a;
      4'h2: e.res = {8'd0, n};
      4'h3: e.res = evt;
      4'h4: begin
        acc_m = acc_m + a;
        e.res = acc_m;
      end
      4'h5: begin
        acc_m = 32'd0;
        e.res = 32'd0;
      end
      default: e.res = 32'hBADC0DE0;
    endcase
    e.blen = (op == 4'h2 || op == 4'h3) ? nn + 1 : 2;
    cnt_m  = cnt_m + 1;
    e.cnt  = cnt_m;
    e.st   = {cmd[31:24], 21'd0, (op > 4'h5), 2'b10};
    sb.push_back(e);
    set_rw(cmd, a);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge sysClk);
      if (sb.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("idle_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    repeat (2) @(posedge sysClk);
  endtask

  task automatic wait_busy();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysClk);
      if (bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_evt(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge sysClk);
      #1 bus.evtIn = 1'b1;
      repeat (2) @(posedge sysClk);
      #1 bus.evtIn = 1'b0;
      @(posedge sysClk);
    end
  endtask

  initial begin
    int b0;
    bus.rwRegs1D = '0;
    bus.evtIn    = 1'b0;
    repeat (3) @(posedge sysClk);
    #1 usrResetN = 1'b1;

    // idle with CMD=0: tag 0 never triggers
    repeat (100) @(posedge sysClk);
    @(negedge sysClk);
    chk("rst_busy_seen", busy_total, 0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("rst_ro%0d", i), ro(i), 32'd0);

    issue(32'h11000000, 32'hDEADBEEF, 0);
    wait_idle();

    issue(32'h22000064, 32'd0, 0);
    wait_idle();
    issue(32'h32000000, 32'd0, 0);
    wait_idle();

    issue(32'h44000000, 32'hFFFFFFF0, 0);
    wait_idle();
    issue(32'h54000000, 32'h00000020, 0);
    wait_idle();
    issue(32'h65000000, 32'd0, 0);
    wait_idle();

    // edges before acceptance must not count
    pulse_evt(3);
    repeat (10) @(posedge sysClk);
    issue(32'h73000100, 32'd0, 10);
    wait_busy();
    pulse_evt(10);
    wait_idle();

    issue(32'h89000000, 32'd0, 0);
    wait_idle();

    // new tag during DELAY runs after it completes
    issue(32'hA2000014, 32'd0, 0);
    wait_busy();
    repeat (5) @(posedge sysClk);
    issue(32'hB1000000, 32'h00001234, 0);
    wait_idle();

    // a word changing every cycle is never stable
    b0 = busy_total;
    for (int i = 0; i < 40; i++)
      set_rw({4'hC + 4'(i % 3), 4'h1, 24'(i + 1)}, 32'd7);
    set_rw(32'hB1000000, 32'h00001234);
    repeat (20) @(posedge sysClk);
    chk("unstable_busy", busy_total, b0);

    // reset in the middle of a DELAY
    issue(32'hC2000064, 32'd0, 0);
    wait_busy();
    repeat (10) @(posedge sysClk);
    #1;
    usrResetN    = 1'b0;
    bus.rwRegs1D = '0;
    sb.delete();
    acc_m = 32'd0;
    cnt_m = 32'd0;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("mid_rst_ro%0d", i), ro(i), 32'd0);
    @(posedge sysClk);
    #1 usrResetN = 1'b1;
    b0 = busy_total;
    repeat (30) @(posedge sysClk);
    chk("post_rst_idle", busy_total, b0);
    issue(32'hD1000000, 32'h00000055, 0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
